truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/tt_pkg.sv | 14 +
 rtl/settle_timer.sv | 34 +++
 rtl/truth_table_sequencer.sv | 119 +++++++++++
 tb/tb_truth_table_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sequencer.
package tt_pkg;

  localparam int unsigned NInDefault = 2;
  localparam int unsigned SettleW    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag; paces how long each vector is held.
module settle_timer
  import tt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [SettleW-1:0] load_val,
  input  logic               enable,
  output logic               zero
);

  logic [SettleW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - SettleW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every stimulus vector, holds it SETTLE cycles, then compares two responses.
module truth_table_sequencer
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = NInDefault,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            resp_a,
  input  logic            resp_b,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            mismatch,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam logic [N_IN-1:0]    LastVec    = '1;
  localparam logic [N_IN-1:0]    StimOne    = N_IN'(1);
  localparam logic [N_IN:0]      ErrOne     = (N_IN + 1)'(1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fev_q, fev_d;
  logic            fvalid_q, fvalid_d;
  logic            mism_q, mism_d;
  logic            tmr_load, tmr_en, tmr_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SettleLoad),
    .enable   (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fvalid_d = fvalid_q;
    mism_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StDrive;
          stim_d   = '0;
          err_d    = '0;
          fev_d    = '0;
          fvalid_d = 1'b0;
          tmr_load = 1'b1;
        end
      end
      StDrive: begin
        if (tmr_zero) begin
          state_d = StSample;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StSample: begin
        if (resp_a != resp_b) begin
          err_d  = err_q + ErrOne;
          mism_d = 1'b1;
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fev_d    = stim_q;
          end
        end
        // Last vector: park in DONE with stim left on the final value.
        if (stim_q == LastVec) begin
          state_d = StDone;
        end else begin
          state_d  = StDrive;
          stim_d   = stim_q + StimOne;
          tmr_load = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      stim_q   <= '0;
      err_q    <= '0;
      fev_q    <= '0;
      fvalid_q <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fvalid_q <= fvalid_d;
      mism_q   <= mism_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = (state_q == StDrive) || (state_q == StSample);
  assign done            = (state_q == StDone);
  assign mismatch        = mism_q;
  assign err_count       = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fvalid_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: one instance with SETTLE=1 and one with SETTLE=3 share a muxed checker.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;   // 0: SETTLE=1 instance, 1: SETTLE=3 instance
  int   mode = 0;     // 0: equal, 1: resp_b stuck at 1, 2: resp_b inverted at vector 3

  always #5 clk = ~clk;

  logic [1:0] stim1, stim3, fev1, fev3;
  logic [2:0] err1, err3;
  logic       busy1, busy3, done1, done3, mism1, mism3, fv1, fv3;
  logic       ra1, rb1, ra3, rb3;
  logic       start1, start3;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  function automatic logic resp_b_of(input int m, input logic [1:0] v);
    logic a;
    a = v[1] & v[0];
    case (m)
      1:       return 1'b1;
      2:       return (v == 2'd3) ? ~a : a;
      default: return a;
    endcase
  endfunction

  always_comb begin
    ra1 = stim1[1] & stim1[0];
    ra3 = stim3[1] & stim3[0];
    rb1 = resp_b_of(mode, stim1);
    rb3 = resp_b_of(mode, stim3);
  end

  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .resp_a(ra1), .resp_b(rb1),
    .stim(stim1), .busy(busy1), .done(done1), .mismatch(mism1), .err_count(err1),
    .first_err_vec(fev1), .first_err_valid(fv1)
  );

  truth_table_sequencer #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .resp_a(ra3), .resp_b(rb3),
    .stim(stim3), .busy(busy3), .done(done3), .mismatch(mism3), .err_count(err3),
    .first_err_vec(fev3), .first_err_valid(fv3)
  );

  logic [1:0] o_stim, o_fev;
  logic [2:0] o_err;
  logic       o_busy, o_done, o_mism, o_fv;
  assign o_stim = sel ? stim3 : stim1;
  assign o_fev  = sel ? fev3  : fev1;
  assign o_err  = sel ? err3  : err1;
  assign o_busy = sel ? busy3 : busy1;
  assign o_done = sel ? done3 : done1;
  assign o_mism = sel ? mism3 : mism1;
  assign o_fv   = sel ? fv3   : fv1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: does vector v produce a differing compare under mode m?
  function automatic bit mis_at(input int m, input int v);
    logic [1:0] vv;
    vv = 2'(v);
    return (vv[1] & vv[0]) != resp_b_of(m, vv);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, ".stim"}, int'(o_stim), 0);
    chk({tag, ".busy"}, int'(o_busy), 0);
    chk({tag, ".done"}, int'(o_done), 0);
    chk({tag, ".mism"}, int'(o_mism), 0);
    chk({tag, ".err"},  int'(o_err),  0);
    chk({tag, ".fev"},  int'(o_fev),  0);
    chk({tag, ".fv"},   int'(o_fv),   0);
  endtask

  // Full sweep from IDLE/DONE: per-edge check of stim/busy/done/mismatch, then results.
  task automatic run_sweep(input int m, input bit s, input int exp_err, input int exp_fev,
                           input bit exp_fv, input bit hold_start);
    int settle, total, pulses, vec;
    bit exp_m;
    mode   = m;
    sel    = s;
    settle = s ? 3 : 1;
    total  = 4 * (settle + 1);
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk("start.stim", int'(o_stim), 0);
    chk("start.busy", int'(o_busy), 1);
    chk("start.err", int'(o_err), 0);
    chk("start.fv", int'(o_fv), 0);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      vec   = k / (settle + 1);
      exp_m = ((k % (settle + 1)) == 0) && mis_at(m, vec - 1);
      chk($sformatf("e%0d.stim", k), int'(o_stim), (vec > 3) ? 3 : vec);
      chk($sformatf("e%0d.busy", k), int'(o_busy), (k < total) ? 1 : 0);
      chk($sformatf("e%0d.done", k), int'(o_done), (k == total) ? 1 : 0);
      chk($sformatf("e%0d.mism", k), int'(o_mism), int'(exp_m));
      if (o_mism) pulses++;
    end
    chk("res.err", int'(o_err), exp_err);
    chk("res.fv", int'(o_fv), int'(exp_fv));
    if (exp_fv) chk("res.fev", int'(o_fev), exp_fev);
    chk("res.pulses", pulses, exp_err);
    if (!hold_start) begin
      repeat (2) @(negedge clk);
      chk("hold.done", int'(o_done), 1);
      chk("hold.err", int'(o_err), exp_err);
      chk("hold.stim", int'(o_stim), 3);
      chk("hold.mism", int'(o_mism), 0);
    end
  endtask

  typedef struct {
    int m;
    bit s;
    int exp_err;
    int exp_fev;
    bit exp_fv;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{m: 0, s: 1'b0, exp_err: 0, exp_fev: 0, exp_fv: 1'b0};
    tbl[1] = '{m: 1, s: 1'b0, exp_err: 3, exp_fev: 0, exp_fv: 1'b1};
    tbl[2] = '{m: 2, s: 1'b0, exp_err: 1, exp_fev: 3, exp_fv: 1'b1};
    tbl[3] = '{m: 0, s: 1'b1, exp_err: 0, exp_fev: 0, exp_fv: 1'b0};
    tbl[4] = '{m: 1, s: 1'b1, exp_err: 3, exp_fev: 0, exp_fv: 1'b1};
    tbl[5] = '{m: 2, s: 1'b1, exp_err: 1, exp_fev: 3, exp_fv: 1'b1};

    #12;
    check_all_zero("reset1");
    sel = 1'b1;
    check_all_zero("reset3");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    foreach (tbl[i]) begin
      run_sweep(tbl[i].m, tbl[i].s, tbl[i].exp_err, tbl[i].exp_fev, tbl[i].exp_fv, 1'b0);
    end

    // Async reset in the middle of a sweep, then a clean sweep.
    mode = 1;
    sel  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst.err", int'(o_err), 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_rst");
    run_sweep(1, 1'b0, 3, 0, 1'b1, 1'b0);

    // start held high: no restart while busy, restart from DONE clears results.
    run_sweep(1, 1'b0, 3, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("restart.busy", int'(o_busy), 1);
    chk("restart.done", int'(o_done), 0);
    chk("restart.err", int'(o_err), 0);
    chk("restart.fv", int'(o_fv), 0);
    chk("restart.stim", int'(o_stim), 0);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!o_done && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("restart.finished", int'(o_done), 1);
      chk("restart.cycles", n, 8);
      chk("restart.final_err", int'(o_err), 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
